// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helper and parameter legality checks for the FIFO slice
// Exports:
//   fifo_cnt_w(depth)                 width of pointers/occupancy for a given depth
//   fifo_depth_ok(depth)              depth is a power of two and at least 2
//   fifo_thresh_ok(depth, af, ae)     thresholds fall inside their legal ranges
package fifo_pkg;

    // One extra bit beyond the index so full and empty stay distinguishable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_depth_ok(input int depth);
        return depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction

    function automatic bit fifo_thresh_ok(input int depth, input int af, input int ae);
        return af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write index
//   wdata  write data
//   raddr  read index
//   rdata  read data, combinational from raddr
module fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_ex.sv
// sync_fifo_ex: synchronous FIFO with registered or show-ahead read, flush, thresholds and sticky errors
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   flush                     discard all contents on the next edge
//   wr_req, w_data            write request and data
//   rd_req                    read/pop request
//   err_clr                   clears ovf_o/udf_o
//   r_data, r_valid           read data and its valid qualifier
//   full_o, empty_o           occupancy == DEPTH / == 0
//   almost_full_o             occupancy >= AF_THRESH
//   almost_empty_o            occupancy <= AE_THRESH
//   count_o                   occupancy
//   ovf_o, udf_o              sticky overflow / underflow
module sync_fifo_ex
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 32,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          wr_req,
    input  logic [WIDTH-1:0]              w_data,
    input  logic                          rd_req,
    input  logic                          err_clr,
    output logic [WIDTH-1:0]              r_data,
    output logic                          r_valid,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count_o,
    output logic                          ovf_o,
    output logic                          udf_o
);
    localparam int PW = fifo_cnt_w(DEPTH);
    localparam int AW = PW - 1;

    if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_ex: DEPTH must be a power of two >= 2");
    end
    if (!fifo_thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_ex: AF_THRESH or AE_THRESH out of range");
    end

    logic [PW-1:0]    wr_ptr, rd_ptr, count;
    logic [WIDTH-1:0] head;
    logic             rd_acc, wr_acc, mem_we;

    // Pointers wrap modulo 2*DEPTH, so their difference is the exact occupancy.
    assign count          = wr_ptr - rd_ptr;
    assign count_o        = count;
    assign empty_o        = count == '0;
    assign full_o         = count == PW'(DEPTH);
    assign almost_full_o  = count >= PW'(AF_THRESH);
    assign almost_empty_o = count <= PW'(AE_THRESH);

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
    assign rd_acc = rd_req & ~empty_o;
    assign wr_acc = wr_req & (~full_o | rd_acc);
    assign mem_we = wr_acc & ~flush;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_o  <= 1'b0;
            udf_o  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            // A new error in the same cycle as err_clr keeps the flag set.
            ovf_o <= (wr_req & full_o & ~rd_acc) | (ovf_o & ~err_clr);
            udf_o <= (rd_req & empty_o) | (udf_o & ~err_clr);
        end

    fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (w_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    if (FWFT != 0) begin : g_fwft
        assign r_data  = empty_o ? '0 : head;
        assign r_valid = ~empty_o;
    end else begin : g_reg
        always_ff @(posedge clk or negedge rstn)
            if (!rstn) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= rd_acc & ~flush;
                if (rd_acc & ~flush) r_data <= head;
            end
    end
endmodule
